// File: rtl/mfp_ahb_bot_fifo_pkg.sv
// mfp_ahb_bot_fifo_pkg: register offsets and field positions for the bot FIFO slave
package mfp_ahb_bot_fifo_pkg;
  localparam logic [1:0] BF_DATA   = 2'd0;
  localparam logic [1:0] BF_STATUS = 2'd1;
  localparam logic [1:0] BF_CTRL   = 2'd2;
  localparam logic [1:0] BF_THRESH = 2'd3;
  localparam int CTRL_CAP   = 0;
  localparam int CTRL_IRQ   = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_CNT   = 8;
  localparam int ST_OVF   = 31;
endpackage

// File: rtl/mfp_ahb_bot_fifo_sync.sv
// bot_sync_fifo: synchronous FIFO with combinational head read and flush
module bot_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // a full FIFO still takes a push when the head leaves on the same edge
  assign wr = push & (~full | (pop & ~empty));
  assign rd = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/mfp_ahb_bot_fifo.sv
// mfp_ahb_bot_fifo: AHB-lite slave buffering rojobot BOT_INFO updates for batched reads
module mfp_ahb_bot_fifo
  import mfp_ahb_bot_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 7
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [7:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  input  logic [31:0] BOT_INFO,
  input  logic        BOT_UPDT,
  output logic        BOT_IRQ
);
  logic act, pop, push, flush, full, empty, ovf, dp_write;
  logic [1:0] dp_addr, ctrl;
  logic [CW-1:0] count, thresh;
  logic [31:0] dout, status, rd_mux;
  logic unused_ok;
  assign unused_ok = ^{HADDR[7:4], HADDR[1:0], HTRANS[0], HWDATA[31:CW]};
  assign act   = HSEL & HTRANS[1];
  assign pop   = act & ~HWRITE & (HADDR[3:2] == BF_DATA) & ~empty;
  assign push  = BOT_UPDT & ctrl[CTRL_CAP];
  assign flush = dp_write & (dp_addr == BF_CTRL) & HWDATA[CTRL_FLUSH];
  always_comb begin
    status = '0;
    status[ST_OVF] = ovf;
    status[ST_CNT +: CW] = count;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    rd_mux = HADDR[3:2] == BF_DATA   ? (empty ? 32'd0 : dout) :
             HADDR[3:2] == BF_STATUS ? status :
             HADDR[3:2] == BF_CTRL   ? {30'd0, ctrl} : 32'(thresh);
  end
  bot_sync_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(HCLK), .rst(HRESET), .push(push), .pop(pop), .flush(flush),
    .din(BOT_INFO), .dout(dout), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_addr  <= '0;
      dp_write <= 1'b0;
      HRDATA   <= '0;
      ctrl     <= '0;
      thresh   <= '0;
      ovf      <= 1'b0;
      BOT_IRQ  <= 1'b0;
    end else begin
      dp_write <= act & HWRITE;
      if (act) dp_addr <= HADDR[3:2];
      if (act & ~HWRITE) HRDATA <= rd_mux;
      if (dp_write && dp_addr == BF_CTRL) ctrl <= HWDATA[1:0];
      if (dp_write && dp_addr == BF_THRESH) thresh <= HWDATA[CW-1:0];
      ovf <= flush ? 1'b0 : (push & full & ~pop) ? 1'b1 : ovf;
      BOT_IRQ <= ctrl[CTRL_IRQ] & (thresh != '0) & (count >= thresh);
    end
  end
endmodule

// File: tb/tb_mfp_ahb_bot_fifo.sv
// tb_mfp_ahb_bot_fifo: directed self-checking bench for the bot FIFO slave
module tb_mfp_ahb_bot_fifo;
  logic HCLK = 0, HRESET = 1, HWRITE = 0, HSEL = 0, BOT_UPDT = 0, BOT_IRQ;
  logic [7:0] HADDR = 0;
  logic [1:0] HTRANS = 0;
  logic [31:0] HWDATA = 0, HRDATA, BOT_INFO = 0, rd;
  int n_vec = 0, n_err = 0;

  mfp_ahb_bot_fifo dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HSEL(HSEL), .HRDATA(HRDATA), .BOT_INFO(BOT_INFO),
    .BOT_UPDT(BOT_UPDT), .BOT_IRQ(BOT_IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
    @(negedge HCLK); bus_idle(); HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
    @(negedge HCLK); bus_idle(); d = HRDATA;
  endtask

  task automatic bot_push(input logic [31:0] v);
    @(negedge HCLK); BOT_UPDT = 1; BOT_INFO = v;
    @(negedge HCLK); BOT_UPDT = 0;
  endtask

  initial begin
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); HRESET = 0;
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_irq", {31'd0, BOT_IRQ}, 0);
    ahb_read(8'h4, rd); chk("rst_status", rd, 32'h1);

    ahb_write(8'h8, 32'h1);
    bot_push(32'h11223344);
    bot_push(32'h55667788);
    ahb_read(8'h4, rd); chk("basic_status", rd, 32'h200);
    ahb_read(8'h0, rd); chk("basic_pop0", rd, 32'h11223344);
    ahb_read(8'h0, rd); chk("basic_pop1", rd, 32'h55667788);
    ahb_read(8'h0, rd); chk("basic_empty_pop", rd, 0);
    ahb_read(8'h4, rd); chk("basic_status_empty", rd, 32'h1);

    for (int i = 0; i < 17; i++) bot_push(32'h100 + i);
    ahb_read(8'h4, rd); chk("ovf_status", rd, 32'h80001002);
    for (int i = 0; i < 16; i++) begin
      ahb_read(8'h0, rd); chk($sformatf("ovf_drain%0d", i), rd, 32'h100 + i);
    end
    ahb_read(8'h4, rd); chk("ovf_sticky", rd, 32'h80000001);
    ahb_write(8'h8, 32'h5);
    ahb_read(8'h4, rd); chk("flush_status", rd, 32'h1);
    ahb_read(8'h8, rd); chk("flush_ctrl_rb", rd, 32'h1);

    for (int i = 0; i < 16; i++) bot_push(32'h200 + i);
    ahb_read(8'h4, rd); chk("full_status", rd, 32'h1002);
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 8'h0; BOT_UPDT = 1; BOT_INFO = 32'h2FF;
    @(negedge HCLK); bus_idle(); BOT_UPDT = 0;
    chk("pp_head", HRDATA, 32'h200);
    ahb_read(8'h4, rd); chk("pp_status", rd, 32'h1002);
    for (int i = 1; i < 16; i++) begin
      ahb_read(8'h0, rd); chk($sformatf("pp_drain%0d", i), rd, 32'h200 + i);
    end
    ahb_read(8'h0, rd); chk("pp_last", rd, 32'h2FF);
    ahb_read(8'h4, rd); chk("pp_empty", rd, 32'h1);

    ahb_write(8'hC, 32'h3);
    ahb_write(8'h8, 32'h3);
    ahb_read(8'hC, rd); chk("thresh_rb", rd, 32'h3);
    bot_push(32'hA0);
    bot_push(32'hA1);
    chk("irq_two", {31'd0, BOT_IRQ}, 0);
    bot_push(32'hA2);
    chk("irq_same_cycle", {31'd0, BOT_IRQ}, 0);
    @(negedge HCLK); chk("irq_rise", {31'd0, BOT_IRQ}, 1);
    ahb_read(8'h0, rd); chk("irq_pop_data", rd, 32'hA0);
    chk("irq_hold", {31'd0, BOT_IRQ}, 1);
    @(negedge HCLK); chk("irq_fall", {31'd0, BOT_IRQ}, 0);
    ahb_write(8'hC, 32'h0);
    bot_push(32'hA3);
    repeat (3) @(negedge HCLK);
    ahb_read(8'h4, rd); chk("irq_off_status", rd, 32'h300);
    chk("irq_thresh0", {31'd0, BOT_IRQ}, 0);

    @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 8'h8;
    @(negedge HCLK); bus_idle(); HWDATA = 32'h3; HRESET = 1;
    @(negedge HCLK); HRESET = 0;
    ahb_read(8'h8, rd); chk("midrst_ctrl", rd, 0);
    bot_push(32'hBB);
    ahb_read(8'h4, rd); chk("midrst_status", rd, 32'h1);
    chk("midrst_irq", {31'd0, BOT_IRQ}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
